// File: rtl/cpu_core_pkg.sv
// Shared types for the parametrised bus-multiplexed CPU core: opcodes, FSM states, flag indices.
package cpu_core_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_LD  = 4'h2,
        OP_ST  = 4'h3,
        OP_MOV = 4'h4,
        OP_ADD = 4'h5,
        OP_SUB = 4'h6,
        OP_AND = 4'h7,
        OP_OR  = 4'h8,
        OP_XOR = 4'h9,
        OP_JMP = 4'hA,
        OP_JZ  = 4'hB,
        OP_JC  = 4'hC,
        OP_HLT = 4'hF
    } opcode_t;

    // Encoding is exported unchanged on stage_no.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_IMM_LO = 3'd2,
        ST_IMM_HI = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned NFLAGS = 2;

endpackage

// File: rtl/alu_p.sv
// Combinational ALU: ADD/SUB report carry/borrow, logic ops clear carry; zero from result.
module alu_p
    import cpu_core_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide;

    // The extra top bit is the carry for ADD and the borrow for SUB; logic ops leave it 0.
    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            default: wide = {1'b0, a};
        endcase
    end

    assign result = wide[DATA_W-1:0];
    assign carry  = wide[DATA_W];
    assign zero   = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/cpu_core_p.sv
// Parametrised multi-cycle CPU core with register file, valid/ready memory port, halt/resume and illegal trap.
module cpu_core_p
    import cpu_core_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned NREGS    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              run,
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        stage_no,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int unsigned RW = $clog2(NREGS);

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   ir;
    logic [DATA_W-1:0]   lo;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [NFLAGS-1:0]   flags;

    opcode_t             op;
    logic [RW-1:0]       rd;
    logic [RW-1:0]       rs;
    logic [ADDR_W-1:0]   pc_inc;
    logic [2*DATA_W-1:0] op_addr_full;
    logic [ADDR_W-1:0]   op_addr;
    logic                jump_taken;
    logic                accept;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;
    logic                alu_zero;

    assign op           = opcode_t'(ir[DATA_W-1 -: 4]);
    assign rd           = ir[RW-1:0];
    assign rs           = ir[2*RW-1:RW];
    assign pc_inc       = pc + ADDR_W'(1);
    assign op_addr_full = {mem_rdata, lo};
    assign op_addr      = op_addr_full[ADDR_W-1:0];
    assign accept       = mem_req && mem_ready;
    assign jump_taken   = (op == OP_JMP)
                       || (op == OP_JZ && flags[FLAG_Z])
                       || (op == OP_JC && flags[FLAG_C]);

    assign stage_no = state;
    assign pc_out   = pc;

    alu_p #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (regs[rd]),
        .b      (regs[rs]),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Bus outputs are registered: each transition that enters a requesting state
    // launches the request for that state, so back-to-back transfers need no idle cycle.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state     <= ST_FETCH;
            pc        <= ADDR_W'(RESET_PC);
            ir        <= '0;
            lo        <= '0;
            regs      <= '{default: '0};
            flags     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata;
                        pc      <= pc_inc;
                        mem_req <= 1'b0;
                        state   <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    state    <= ST_FETCH;
                    mem_req  <= 1'b1;
                    mem_addr <= pc;
                    case (op)
                        OP_NOP: ;
                        OP_MOV: regs[rd] <= regs[rs];
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            regs[rd]      <= alu_result;
                            flags[FLAG_C] <= alu_carry;
                            flags[FLAG_Z] <= alu_zero;
                        end
                        OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JC: state <= ST_IMM_LO;
                        OP_HLT: begin
                            state   <= ST_HALT;
                            mem_req <= 1'b0;
                            halted  <= 1'b1;
                        end
                        default: begin
                            state   <= ST_HALT;
                            mem_req <= 1'b0;
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                        end
                    endcase
                end

                ST_IMM_LO: begin
                    if (accept) begin
                        pc       <= pc_inc;
                        mem_addr <= pc_inc;
                        if (op == OP_LDI) begin
                            regs[rd] <= mem_rdata;
                            state    <= ST_FETCH;
                        end else begin
                            lo    <= mem_rdata;
                            state <= ST_IMM_HI;
                        end
                    end
                end

                ST_IMM_HI: begin
                    if (accept) begin
                        pc       <= pc_inc;
                        mem_addr <= pc_inc;
                        state    <= ST_FETCH;
                        if (op == OP_LD || op == OP_ST) begin
                            state     <= ST_MEM;
                            mem_addr  <= op_addr;
                            mem_we    <= (op == OP_ST);
                            mem_wdata <= regs[rd];
                        end else if (jump_taken) begin
                            pc       <= op_addr;
                            mem_addr <= op_addr;
                        end
                    end
                end

                ST_MEM: begin
                    if (accept) begin
                        if (op == OP_LD) begin
                            regs[rd] <= mem_rdata;
                        end
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        state    <= ST_FETCH;
                    end
                end

                ST_HALT: begin
                    if (run) begin
                        halted   <= 1'b0;
                        illegal  <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        state    <= ST_FETCH;
                    end
                end

                default: begin
                    state   <= ST_FETCH;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_p.sv
// Scoreboard bench for cpu_core_p: an ISA-level interpreter predicts every bus transfer.
module tb_cpu_core_p;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req, mem_we, mem_ready, run, halted, illegal;
    logic [15:0] mem_addr, pc_out;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [2:0]  stage_no;

    always #5 clk = ~clk;

    cpu_core_p #(.DATA_W(8), .ADDR_W(16), .NREGS(4), .RESET_PC(0)) dut (
        .clk_in     (clk),
        .reset_n_in (reset_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .run        (run),
        .halted     (halted),
        .illegal    (illegal),
        .stage_no   (stage_no),
        .pc_out     (pc_out)
    );

    logic [7:0] dmem [0:65535];
    logic [7:0] mmem [0:65535];
    assign mem_rdata = dmem[mem_addr];

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } xact_t;

    xact_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    ready_pct = 100;

    logic [7:0]  m_r [4];
    logic        m_c, m_z, m_halt, m_ill;
    logic [15:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic void push(input logic [15:0] a, input logic w, input logic [7:0] d);
        exp_q.push_back('{addr: a, we: w, wdata: d});
    endfunction

    // Instruction-level interpreter: runs from m_pc until HLT/illegal, queueing the expected bus traffic.
    task automatic model_exec();
        logic [7:0]  ir, a, b, lo, hi;
        logic [15:0] ea;
        logic [1:0]  rd;
        int unsigned ra, rb, res;
        int          steps = 0;
        while (!m_halt && steps < 2000) begin
            steps++;
            push(m_pc, 1'b0, 8'h00);
            ir = mmem[m_pc];
            m_pc = m_pc + 16'd1;
            rd = ir[1:0];
            a  = m_r[ir[1:0]];
            b  = m_r[ir[3:2]];
            ra = a;
            rb = b;
            case (ir[7:4])
                4'h0: ;
                4'h1: begin
                    push(m_pc, 1'b0, 8'h00);
                    m_r[rd] = mmem[m_pc];
                    m_pc = m_pc + 16'd1;
                end
                4'h2, 4'h3, 4'hA, 4'hB, 4'hC: begin
                    push(m_pc, 1'b0, 8'h00);
                    lo = mmem[m_pc];
                    m_pc = m_pc + 16'd1;
                    push(m_pc, 1'b0, 8'h00);
                    hi = mmem[m_pc];
                    m_pc = m_pc + 16'd1;
                    ea = {hi, lo};
                    if (ir[7:4] == 4'h2) begin
                        push(ea, 1'b0, 8'h00);
                        m_r[rd] = mmem[ea];
                    end else if (ir[7:4] == 4'h3) begin
                        push(ea, 1'b1, a);
                        mmem[ea] = a;
                    end else if (ir[7:4] == 4'hA || (ir[7:4] == 4'hB && m_z) || (ir[7:4] == 4'hC && m_c)) begin
                        m_pc = ea;
                    end
                end
                4'h4: m_r[rd] = b;
                4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                    case (ir[7:4])
                        4'h5: begin res = ra + rb; m_c = (res > 255); end
                        4'h6: begin res = (ra - rb) & 32'hFF; m_c = (ra < rb); end
                        4'h7: begin res = ra & rb; m_c = 1'b0; end
                        4'h8: begin res = ra | rb; m_c = 1'b0; end
                        default: begin res = ra ^ rb; m_c = 1'b0; end
                    endcase
                    m_r[rd] = res[7:0];
                    m_z = (res[7:0] == 8'h00);
                end
                4'hF: m_halt = 1'b1;
                default: begin
                    m_halt = 1'b1;
                    m_ill  = 1'b1;
                end
            endcase
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            dmem[i] = 8'h00;
            mmem[i] = 8'h00;
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        dmem[a] = d;
        mmem[a] = d;
    endtask

    // Places the low n bytes of 'bytes' at base, most significant byte first.
    task automatic load(input logic [15:0] base, input logic [95:0] bytes, input int n);
        for (int i = 0; i < n; i++) poke(base + 16'(i), bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic wait_halt(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (halted !== 1'b1 && edges < 4000);
        check("halt_reached", halted, 1);
    endtask

    task automatic start_and_wait(output int edges);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        m_r = '{default: 8'h00};
        m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0; m_ill = 1'b0; m_pc = 16'h0000;
        model_exec();
        reset_n = 1'b1;
        wait_halt(edges);
    endtask

    task automatic post_checks();
        int nreq = 0;
        check("queue_drained", exp_q.size(), 0);
        repeat (4) begin
            @(negedge clk);
            if (mem_req !== 1'b0) nreq++;
        end
        check("halt_no_req", nreq, 0);
        check("pc_out", pc_out, m_pc);
        check("illegal", illegal, m_ill);
        check("halt_stage", stage_no, 5);
    endtask

    task automatic reset_checks();
        reset_n = 1'b0;
        #1;
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        check("rst_pc", pc_out, 0);
        check("rst_stage", stage_no, 0);
    endtask

    task automatic gen_random();
        int          kind [24];
        logic [15:0] ad [24];
        int          n, total;
        logic [15:0] cur, ea;
        logic [1:0]  rd, rs;
        logic [3:0]  k;
        clear_mem();
        for (int j = 0; j < 16; j++) poke(16'h8000 + 16'(j), 8'($urandom_range(0, 255)));
        n = $urandom_range(6, 16);
        total = n + 5;
        for (int i = 0; i < n; i++) kind[i] = $urandom_range(0, 12);
        for (int i = n; i < n + 4; i++) kind[i] = 3;
        kind[n+4] = 15;
        cur = 16'h0000;
        for (int i = 0; i < total; i++) begin
            ad[i] = cur;
            if (kind[i] == 1) cur = cur + 16'd2;
            else if (kind[i] == 2 || kind[i] == 3 || kind[i] >= 10 && kind[i] <= 12) cur = cur + 16'd3;
            else cur = cur + 16'd1;
        end
        for (int i = 0; i < total; i++) begin
            k  = kind[i][3:0];
            rd = 2'($urandom_range(0, 3));
            rs = 2'($urandom_range(0, 3));
            ea = 16'h8000 + 16'($urandom_range(0, 15));
            if (i >= n && i < n + 4) begin
                rd = 2'(i - n);
                ea = 16'h8100 + 16'(i - n);
            end
            if (k >= 4'hA && k <= 4'hC) ea = ad[$urandom_range(i + 1, total - 1)];
            poke(ad[i], {k, rs, rd});
            if (k == 4'h1) poke(ad[i] + 16'd1, 8'($urandom_range(0, 255)));
            if (k == 4'h2 || k == 4'h3 || (k >= 4'hA && k <= 4'hC)) begin
                poke(ad[i] + 16'd1, ea[7:0]);
                poke(ad[i] + 16'd2, ea[15:8]);
            end
        end
    endtask

    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 mem_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor: pops one expected transfer per accept and checks request hold during wait states.
    initial begin
        logic  pend;
        xact_t px, e;
        pend = 1'b0;
        px = '0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    n_checks++;
                    if (!(mem_req === 1'b1 && mem_addr === px.addr && mem_we === px.we
                          && (!px.we || mem_wdata === px.wdata))) begin
                        n_fail++;
                        $display("FAIL req_hold: got req %0b addr %0h we %0b wdata %0h, expected req 1 addr %0h we %0b wdata %0h",
                                 mem_req, mem_addr, mem_we, mem_wdata, px.addr, px.we, px.wdata);
                    end
                end
                if (mem_req === 1'b1 && mem_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_req: got addr %0h we %0b, expected no transfer", mem_addr, mem_we);
                    end else begin
                        e = exp_q.pop_front();
                        check("bus_addr", mem_addr, e.addr);
                        check("bus_we", mem_we, e.we);
                        if (e.we) check("bus_wdata", mem_wdata, e.wdata);
                    end
                    if (mem_we === 1'b1) dmem[mem_addr] = mem_wdata;
                end
                pend = (mem_req === 1'b1) && (mem_ready !== 1'b1);
                px = '{addr: mem_addr, we: mem_we, wdata: mem_wdata};
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int edges;
        reset_n = 1'b0;
        run = 1'b0;
        clear_mem();
        #1 reset_checks();

        // LDI r0,#F0; LDI r1,#20; ADD r0,r1; HLT -- first edge after release launches the fetch
        load(16'h0000, 96'h10F0_1120_54F0, 6);
        start_and_wait(edges);
        check("p1_halt_edges", edges, 11);
        post_checks();
        check("p1_pc", pc_out, 16'h0006);

        // Same prefix, then JZ (not taken, Z=0), JC taken (C=1), store r0
        clear_mem();
        load(16'h0000, 96'h10F0_1120_54B0_5000_C040_00, 11);
        poke(16'h000B, 8'hF0);
        load(16'h0040, 96'h3000_80F0, 4);
        start_and_wait(edges);
        post_checks();
        check("p1b_r0", dmem[16'h8000], 8'h10);
        check("p1b_pc", pc_out, 16'h0044);

        // LDI r2,#5A; ST r2,[1234]; LD r3,[1234]; ST r3,[2000]; HLT at full and ~30% ready
        for (int pass = 0; pass < 2; pass++) begin
            clear_mem();
            load(16'h0000, 96'h125A_3234_1223_3412_3300_20, 11);
            poke(16'h000B, 8'hF0);
            @(negedge clk);
            ready_pct = (pass == 0) ? 100 : 30;
            start_and_wait(edges);
            post_checks();
            check("p2_st", dmem[16'h1234], 8'h5A);
            check("p2_ld", dmem[16'h2000], 8'h5A);
            check("p2_pc", pc_out, 16'h000C);
            if (pass == 0) begin
                @(posedge clk);
                #1 reset_checks();
            end
        end
        @(negedge clk);
        ready_pct = 100;

        // XOR r1,r1; JZ 0040
        clear_mem();
        load(16'h0000, 96'h95B0_4000_F0, 5);
        poke(16'h0040, 8'hF0);
        start_and_wait(edges);
        post_checks();
        check("jz_taken_pc", pc_out, 16'h0041);

        // r0=50, r1=10, SUB r0,r1 (no borrow); JC not taken
        clear_mem();
        load(16'h0000, 96'h1050_1110_64C0_4000_F0, 9);
        poke(16'h0040, 8'hF0);
        start_and_wait(edges);
        post_checks();
        check("jc_not_taken_pc", pc_out, 16'h0009);

        // Illegal 0xD0, then resume into LDI r0,#33; ST r0,[8000]; HLT
        clear_mem();
        load(16'h0000, 96'hD010_3330_0080_F0, 7);
        start_and_wait(edges);
        post_checks();
        check("ill_flag", illegal, 1);
        check("ill_pc", pc_out, 16'h0001);
        @(posedge clk);
        #1;
        m_halt = 1'b0;
        m_ill = 1'b0;
        model_exec();
        run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        check("run_clears_illegal", illegal, 0);
        check("run_fetch_req", mem_req, 1);
        wait_halt(edges);
        post_checks();
        check("resume_store", dmem[16'h8000], 8'h33);

        // JMP FFFF; LDI r1 wraps its operand fetch to 0000; byte at 0001 is HLT
        clear_mem();
        load(16'h0000, 96'hA0FFFF, 3);
        poke(16'hFFFF, 8'h11);
        start_and_wait(edges);
        post_checks();
        check("wrap_pc", pc_out, 16'h0002);

        // Reset while a fetch is stalled by ready = 0
        clear_mem();
        load(16'h0000, 96'h10F0_1120_54F0, 6);
        @(negedge clk);
        ready_pct = 0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        begin
            int waited = 0;
            while (mem_req !== 1'b1 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
        end
        check("stall_req_seen", mem_req, 1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("reset_drops_req", mem_req, 0);
        check("reset_clears_addr", mem_addr, 0);
        @(negedge clk);
        ready_pct = 100;
        start_and_wait(edges);
        post_checks();

        // Random forward-jumping programs under varying wait states
        for (int t = 0; t < 8; t++) begin
            gen_random();
            @(negedge clk);
            ready_pct = (t % 3 == 0) ? 100 : ((t % 3 == 1) ? 60 : 30);
            start_and_wait(edges);
            post_checks();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
